// File: rtl/mux_lut_pipe.sv
// mux_lut_pipe: pipelined, reprogrammable K-input logic unit on W-bit vectors.
// Each result bit is selected from a 2**K-entry truth table by the matching
// bits of the K operands, using a binary multiplexer tree. The result goes into
// a single valid/ready output register. A saturating counter counts output
// transfers.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   cfg_we, cfg_table   truth-table write strobe and new table (bit i = output for index i)
//   in_valid, in_ready  input handshake (in_ready depends only on the output stage)
//   in_a                K operands; operand j is in_a[j*W +: W]
//   out_valid, out_ready, out_y   registered output stream
//   xfer_cnt            number of completed output transfers, saturates at 16'hFFFF
module mux_lut_pipe #(
  parameter int unsigned     K          = 1,
  parameter int unsigned     W          = 8,
  parameter logic [2**K-1:0] INIT_TABLE = {2**(K-1){2'b01}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [2**K-1:0]  cfg_table,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K*W-1:0]   in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_y,
  output logic [15:0]      xfer_cnt
);

  localparam int unsigned N = 2**K;

  logic [N-1:0] tbl;
  logic [W-1:0] y;
  logic         accept;
  logic         out_hs;

  // One bit of the result. Level l of the tree halves the candidates using
  // operand l's bit. Neighbouring leaves differ only in index bit 0. The
  // reduction is done in place: node i is written only after nodes 2i and
  // 2i+1 have been read at that level.
  function automatic logic lut_bit(input logic [N-1:0] t,
                                   input logic [K*W-1:0] a,
                                   input int unsigned b);
    logic [N-1:0] node;
    node = t;
    for (int unsigned l = 0; l < K; l++) begin
      for (int unsigned i = 0; i < (N >> (l + 1)); i++) begin
        node[i] = a[l*W + b] ? node[2*i + 1] : node[2*i];
      end
    end
    return node[0];
  endfunction

  always_comb begin
    y = '0;
    for (int unsigned b = 0; b < W; b++) begin
      y[b] = lut_bit(tbl, in_a, b);
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  // The result registered on an acceptance uses the table as it is before this
  // edge. A cfg_we in the same cycle only affects later acceptances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl       <= INIT_TABLE;
      out_valid <= 1'b0;
      out_y     <= '0;
      xfer_cnt  <= '0;
    end else begin
      if (cfg_we) begin
        tbl <= cfg_table;
      end
      if (accept) begin
        out_y     <= y;
        out_valid <= 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
      if (out_hs && (xfer_cnt != '1)) begin
        xfer_cnt <= xfer_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mux_lut_pipe.sv
// Testbench for mux_lut_pipe. It uses two instances: a K=1 instance with the
// default table (NOT gate) and a K=2 instance for reprogramming. A
// truth-table reference model predicts out_valid, out_y, xfer_cnt and in_ready
// on every checked cycle.
module tb_mux_lut_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // K=1 instance
  logic        cfg_we1 = 1'b0;
  logic [1:0]  cfg_table1 = '0;
  logic        in_valid1 = 1'b0;
  logic        in_ready1;
  logic [7:0]  in_a1 = '0;
  logic        out_valid1;
  logic        out_ready1 = 1'b0;
  logic [7:0]  out_y1;
  logic [15:0] xfer_cnt1;

  // K=2 instance
  logic        cfg_we2 = 1'b0;
  logic [3:0]  cfg_table2 = '0;
  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [15:0] in_a2 = '0;
  logic        out_valid2;
  logic        out_ready2 = 1'b0;
  logic [7:0]  out_y2;
  logic [15:0] xfer_cnt2;

  mux_lut_pipe #(.K(1), .W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we1), .cfg_table(cfg_table1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_y(out_y1),
    .xfer_cnt(xfer_cnt1)
  );

  mux_lut_pipe #(.K(2), .W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we2), .cfg_table(cfg_table2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_y(out_y2),
    .xfer_cnt(xfer_cnt2)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference state, index 0 = u1, index 1 = u2.
  logic        m_valid [2];
  logic [7:0]  m_y     [2];
  logic [15:0] m_cnt   [2];
  logic [15:0] m_tbl   [2];

  // Reset table for both instances is "NOT operand 0": the table entry is 1
  // exactly when index bit 0 is 0.
  localparam logic [15:0] INIT1 = 16'h0001;
  localparam logic [15:0] INIT2 = 16'h0005;

  function automatic logic [7:0] ref_lut(input logic [15:0] t, input logic [15:0] a, input int k);
    logic [7:0] r;
    int idx;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      idx = 0;
      for (int j = 0; j < k; j++) begin
        if (a[j*8 + b]) idx = idx + (1 << j);
      end
      r[b] = t[idx];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_valid[u] = 1'b0;
      m_y[u]     = '0;
      m_cnt[u]   = '0;
    end
    m_tbl[0] = INIT1;
    m_tbl[1] = INIT2;
  endtask

  task automatic model_edge(input int u, input int k, input logic we, input logic [15:0] ct,
                            input logic iv, input logic [15:0] a, input logic ordy);
    logic acc, hs;
    hs  = m_valid[u] && ordy;
    acc = iv && (!m_valid[u] || ordy);
    if (hs && m_cnt[u] != 16'hFFFF) m_cnt[u] = m_cnt[u] + 16'd1;
    if (acc) begin
      m_y[u]     = ref_lut(m_tbl[u], a, k);
      m_valid[u] = 1'b1;
    end else if (hs) begin
      m_valid[u] = 1'b0;
    end
    if (we) m_tbl[u] = ct;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("u1.out_valid", {31'b0, out_valid1}, {31'b0, m_valid[0]});
    chk("u1.out_y",     {24'b0, out_y1},     {24'b0, m_y[0]});
    chk("u1.xfer_cnt",  {16'b0, xfer_cnt1},  {16'b0, m_cnt[0]});
    chk("u1.in_ready",  {31'b0, in_ready1},  {31'b0, (!m_valid[0] || out_ready1)});
    chk("u2.out_valid", {31'b0, out_valid2}, {31'b0, m_valid[1]});
    chk("u2.out_y",     {24'b0, out_y2},     {24'b0, m_y[1]});
    chk("u2.xfer_cnt",  {16'b0, xfer_cnt2},  {16'b0, m_cnt[1]});
    chk("u2.in_ready",  {31'b0, in_ready2},  {31'b0, (!m_valid[1] || out_ready2)});
  endtask

  // One clock edge: advance the model with the inputs applied before the
  // edge, then sample 1 time unit after the edge.
  task automatic tick(input bit do_chk);
    @(posedge clk);
    model_edge(0, 1, cfg_we1, {14'b0, cfg_table1}, in_valid1, {8'b0, in_a1}, out_ready1);
    model_edge(1, 2, cfg_we2, {12'b0, cfg_table2}, in_valid2, in_a2, out_ready2);
    #1;
    if (do_chk) check_all();
  endtask

  logic [7:0]  held;
  logic [15:0] cnt_before;

  initial begin
    model_reset();

    // Reset state at start-up.
    #3;
    check_all();
    #4 rst_n = 1'b1;

    // Default table on u1 is NOT: A5 -> 5A.
    in_a1 = 8'hA5; in_valid1 = 1'b1; out_ready1 = 1'b1;
    tick(1);
    chk("not_a5", {24'b0, out_y1}, 32'h5A);
    chk("not_valid", {31'b0, out_valid1}, 32'h1);
    in_valid1 = 1'b0;
    tick(1);
    chk("cnt_one", {16'b0, xfer_cnt1}, 32'h1);

    // u2 reprogrammed to AND, then to XOR. op0 = F0, op1 = CC.
    out_ready2 = 1'b1;
    cfg_we2 = 1'b1; cfg_table2 = 4'b1000;
    tick(1);
    cfg_we2 = 1'b0; in_valid2 = 1'b1; in_a2 = 16'hCCF0;
    tick(1);
    chk("and_f0_cc", {24'b0, out_y2}, 32'hC0);
    in_valid2 = 1'b0; cfg_we2 = 1'b1; cfg_table2 = 4'b0110;
    tick(1);
    cfg_we2 = 1'b0; in_valid2 = 1'b1;
    tick(1);
    chk("xor_f0_cc", {24'b0, out_y2}, 32'h3C);

    // Table write in the same cycle as an acceptance: the old table is used.
    in_valid2 = 1'b0; cfg_we2 = 1'b1; cfg_table2 = 4'b1000;
    tick(1);
    cfg_table2 = 4'b0110; in_valid2 = 1'b1; in_a2 = 16'hCCF0;
    tick(1);
    chk("collide_old", {24'b0, out_y2}, 32'hC0);
    cfg_we2 = 1'b0;
    tick(1);
    chk("collide_new", {24'b0, out_y2}, 32'h3C);

    // Backpressure. Drain the output, then stall a result (12 XOR 34 = 26).
    in_valid2 = 1'b0;
    tick(1);
    out_ready2 = 1'b0; in_valid2 = 1'b1; in_a2 = 16'h1234;
    tick(1);
    held = 8'h26;
    chk("stall_load", {24'b0, out_y2}, {24'b0, held});
    cnt_before = xfer_cnt2;
    chk("stall_cnt_model", {16'b0, cnt_before}, {16'b0, m_cnt[1]});
    cfg_we2 = 1'b1; cfg_table2 = 4'b1000;   // rewrite while stalled
    for (int i = 0; i < 5; i++) begin
      in_a2 = 16'($urandom);
      tick(1);
      cfg_we2 = 1'b0;
      chk("stall_hold_y", {24'b0, out_y2}, {24'b0, held});
      chk("stall_in_ready", {31'b0, in_ready2}, 32'h0);
      chk("stall_cnt", {16'b0, xfer_cnt2}, {16'b0, cnt_before});
    end
    out_ready2 = 1'b1; in_a2 = 16'hCCF0;
    tick(1);
    chk("release_new_and", {24'b0, out_y2}, 32'hC0);
    chk("release_valid", {31'b0, out_valid2}, 32'h1);
    chk("release_cnt", {16'b0, xfer_cnt2}, {16'b0, cnt_before + 16'd1});

    // Random traffic on both instances.
    for (int i = 0; i < 300; i++) begin
      cfg_we1    = ($urandom_range(0, 7) == 0);
      cfg_table1 = 2'($urandom);
      in_valid1  = 1'($urandom);
      in_a1      = 8'($urandom);
      out_ready1 = ($urandom_range(0, 3) != 0);
      cfg_we2    = ($urandom_range(0, 7) == 0);
      cfg_table2 = 4'($urandom);
      in_valid2  = 1'($urandom);
      in_a2      = 16'($urandom);
      out_ready2 = ($urandom_range(0, 3) != 0);
      tick(1);
    end

    // Reset asserted mid-stream while results are held.
    cfg_we1 = 1'b0; cfg_we2 = 1'b0;
    in_valid1 = 1'b1; out_ready1 = 1'b0;
    in_valid2 = 1'b1; out_ready2 = 1'b0; in_a2 = 16'h00A5;
    tick(1);
    tick(1);
    chk("pre_reset_valid", {31'b0, out_valid2}, 32'h1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_in_ready", {31'b0, in_ready2}, 32'h1);
    #1 rst_n = 1'b1;
    out_ready2 = 1'b1;
    tick(1);
    chk("post_reset_not", {24'b0, out_y2}, 32'h5A);

    // Counter saturation on u1: continuous handshakes.
    in_valid2 = 1'b0;
    in_valid1 = 1'b1; out_ready1 = 1'b1; in_a1 = 8'h3C;
    for (int i = 0; i < 65540; i++) begin
      in_a1 = 8'(i);
      tick(0);
    end
    check_all();
    chk("sat_cnt", {16'b0, xfer_cnt1}, 32'hFFFF);
    tick(1);
    tick(1);
    chk("sat_hold", {16'b0, xfer_cnt1}, 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
